// File: rtl/bridge_tx.sv
// rtl/bridge_tx.sv - read-completion to "M<hex>\r\n" UART reply encoder with pending-reply FIFO
module bridge_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [7:0]            uart_data_o,
    output logic                  uart_start_o,
    input  logic                  uart_done_i,
    output logic                  busy_o,
    output logic                  overflow_o
);
    localparam int NIB     = DATA_WIDTH / 4;
    localparam int MSG_LEN = NIB + 3;
    localparam int IDX_W   = $clog2(MSG_LEN);
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]      idx, nxt_idx;
    logic [7:0]            nxt_byte;
    logic                  empty, full, pop, push_req, push;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = (state == S_IDLE) && !empty;
    assign push_req = valid_i && !rw_i;
    assign push     = push_req && (!full || pop);
    assign busy_o   = (state != S_IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push) overflow_o <= 1'b1;
        end
    end

    // Byte for the following index; index 0 ('M') is only ever loaded on a pop.
    always_comb begin
        nxt_idx  = idx + 1'b1;
        nxt_byte = 8'h0D;
        if (nxt_idx == IDX_W'(MSG_LEN - 1)) nxt_byte = 8'h0A;
        for (int i = 0; i < NIB; i++) begin
            if (nxt_idx == IDX_W'(i + 1)) nxt_byte = hex_char(shreg[(NIB-1-i)*4 +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            shreg        <= '0;
            idx          <= '0;
            uart_data_o  <= 8'h00;
            uart_start_o <= 1'b0;
        end else begin
            uart_start_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        shreg        <= mem[rd_ptr[AW-1:0]];
                        idx          <= '0;
                        uart_data_o  <= 8'h4D;
                        uart_start_o <= 1'b1;
                        state        <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (uart_done_i) begin
                        if (idx == IDX_W'(MSG_LEN - 1)) begin
                            state <= S_IDLE;
                        end else begin
                            idx          <= nxt_idx;
                            uart_data_o  <= nxt_byte;
                            uart_start_o <= 1'b1;
                            state        <= S_START;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
